// File: rtl/mmcm_drp_pkg.sv
// Shared definitions for the emulated MMCM DRP responder: register map
// addresses, power-on register defaults and the request FSM state encoding.
package mmcm_drp_pkg;

  // DRP register pairs (REG1/REG2) of the emulated MMCM
  localparam logic [6:0] DRP_CLKOUT5_REG1  = 7'h06;
  localparam logic [6:0] DRP_CLKOUT5_REG2  = 7'h07;
  localparam logic [6:0] DRP_CLKOUT0_REG1  = 7'h08;
  localparam logic [6:0] DRP_CLKOUT0_REG2  = 7'h09;
  localparam logic [6:0] DRP_CLKOUT1_REG1  = 7'h0A;
  localparam logic [6:0] DRP_CLKOUT1_REG2  = 7'h0B;
  localparam logic [6:0] DRP_CLKOUT2_REG1  = 7'h0C;
  localparam logic [6:0] DRP_CLKOUT2_REG2  = 7'h0D;
  localparam logic [6:0] DRP_CLKOUT3_REG1  = 7'h0E;
  localparam logic [6:0] DRP_CLKOUT3_REG2  = 7'h0F;
  localparam logic [6:0] DRP_CLKOUT4_REG1  = 7'h10;
  localparam logic [6:0] DRP_CLKOUT4_REG2  = 7'h11;
  localparam logic [6:0] DRP_DIVCLK_REG1   = 7'h12;
  localparam logic [6:0] DRP_DIVCLK_REG2   = 7'h13;
  localparam logic [6:0] DRP_CLKFBOUT_REG1 = 7'h14;
  localparam logic [6:0] DRP_CLKFBOUT_REG2 = 7'h15;

  // Addresses covered by the defaults table; everything else resets to 0
  localparam logic [6:0] DFLT_FIRST = DRP_CLKOUT5_REG1;
  localparam logic [6:0] DFLT_LAST  = DRP_CLKFBOUT_REG2;

  // Power-on values for 0x06..0x15, entry 0 belongs to address 0x06
  localparam logic [15:0] MMCM_DEFAULTS [16] = '{
    16'h1041, 16'h0000,   // CLKOUT5
    16'h1145, 16'h0000,   // CLKOUT0
    16'h1083, 16'h0080,   // CLKOUT1
    16'h1082, 16'h0000,   // CLKOUT2
    16'h1104, 16'h0000,   // CLKOUT3
    16'h1186, 16'h0040,   // CLKOUT4
    16'h1041, 16'h0000,   // DIVCLK
    16'h1208, 16'h0000    // CLKFBOUT
  };

  // Reset value of the register at a given DRP address
  function automatic logic [15:0] drp_default(input logic [6:0] addr);
    logic [6:0] off;
    off = addr - DFLT_FIRST;
    if (addr >= DFLT_FIRST && addr <= DFLT_LAST)
      return MMCM_DEFAULTS[off[3:0]];
    return 16'h0000;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } drp_state_e;

endpackage

// File: rtl/drp_resp_regfile.sv
// 128 x 16 register file: one write port, one registered read port,
// asynchronous reset loads the MMCM default values.
module drp_resp_regfile
  import mmcm_drp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [6:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic        i_re,
  input  logic [6:0]  i_raddr,
  output logic [15:0] o_rdata
);

  logic [15:0] r_mem [128];
  logic [15:0] r_rdata;

  // Storage: defaults on reset, single-word write otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) r_mem[i] <= drp_default(7'(i));
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: captures the addressed word when enabled, holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= 16'h0000;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mmcm_drp_resp.sv
// Emulated MMCM DRP responder: accepts one request at a time, answers with
// a cfg_rdy pulse READY_LAT+1 cycles after the request strobe, and models the
// MMCM lock output. Define DRP_RESP_LOCK_EN to make writes drop locked for
// LOCK_CYCLES cycles; otherwise locked is simply high once out of reset.
module mmcm_drp_resp
  import mmcm_drp_pkg::*;
#(
  parameter int READY_LAT   = 4,
  parameter int LOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_ena,
  input  logic        cfg_wen,
  input  logic [6:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        cfg_rdy,
  output logic        locked,
  output logic        err_busy
);

  if (READY_LAT < 1 || READY_LAT > 15) begin : g_bad_ready_lat
    $error("mmcm_drp_resp: READY_LAT must be 1..15");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock_cycles
    $error("mmcm_drp_resp: LOCK_CYCLES must be 1..65535");
  end

  localparam logic [3:0] LAT_LAST = 4'(READY_LAT - 1);

  drp_state_e  r_state, w_state_next;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [6:0]  r_addr;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_locked;
  logic        w_accept;
  logic        w_done_next;
  logic [15:0] w_rf_rdata;
  logic        w_unused_wdata;

  assign w_unused_wdata = ^cfg_wdata[31:16];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: accept only in IDLE, leave BUSY after READY_LAT cycles
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: if (cfg_ena) begin
        w_state_next = ST_BUSY;
        w_accept     = 1'b1;
      end
      ST_BUSY: if (r_cnt == LAT_LAST) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_done_next = (r_state == ST_BUSY) && (w_state_next == ST_DONE);

  // Request capture and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_wen   <= 1'b0;
      r_addr  <= 7'd0;
      r_wdata <= 16'h0000;
    end else if (w_accept) begin
      r_cnt   <= 4'd0;
      r_wen   <= cfg_wen;
      r_addr  <= cfg_addr;
      r_wdata <= cfg_wdata[15:0];
    end else if (r_state == ST_BUSY) begin
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  // The read port samples the register at acceptance; the write lands on DONE
  drp_resp_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    ((r_state == ST_DONE) && r_wen),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_re    (w_accept && !cfg_wen),
    .i_raddr (cfg_addr),
    .o_rdata (w_rf_rdata)
  );

  // Read data is published entering DONE and held until the next read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_rdata <= 32'h0;
    else if (w_done_next && !r_wen) r_rdata <= {16'h0000, w_rf_rdata};
  end

  // Sticky flag for strobes arriving while a request is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_err <= 1'b0;
    else if (cfg_ena && r_state != ST_IDLE) r_err <= 1'b1;
  end

`ifdef DRP_RESP_LOCK_EN
  localparam logic [16:0] LOCK_RELOAD = 17'(LOCK_CYCLES);
  logic [16:0] r_lock_cnt;
  logic        w_wr_done_next;

  assign w_wr_done_next = w_done_next && r_wen;

  // Lock countdown: one extra count after reset so locked rises LOCK_CYCLES
  // edges after the first one; a write reloads it and drops locked in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= LOCK_RELOAD + 17'd1;
      r_locked   <= 1'b0;
    end else if (w_wr_done_next) begin
      r_lock_cnt <= LOCK_RELOAD;
      r_locked   <= 1'b0;
    end else if (r_lock_cnt != 17'd0) begin
      r_lock_cnt <= r_lock_cnt - 17'd1;
      if (r_lock_cnt == 17'd1) r_locked <= 1'b1;
    end
  end
`else
  // No lock emulation: locked is high from the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_locked <= 1'b0;
    else        r_locked <= 1'b1;
  end
`endif

  assign cfg_rdy   = (r_state == ST_DONE);
  assign cfg_rdata = r_rdata;
  assign err_busy  = r_err;
  assign locked    = r_locked;

endmodule

// File: tb/tb_mmcm_drp_resp.sv
// Bench for mmcm_drp_resp: READY_LAT=4 instance for the main scenarios and a
// READY_LAT=1 instance for back-to-back traffic. Lock checks follow
// DRP_RESP_LOCK_EN.
module tb_mmcm_drp_resp;
  import mmcm_drp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena0 = 1'b0, wen0 = 1'b0, ena1 = 1'b0, wen1 = 1'b0;
  logic [6:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1, locked0, locked1, err0, err1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [15:0] model [2][128];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  mmcm_drp_resp #(.READY_LAT(4), .LOCK_CYCLES(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_ena(ena0), .cfg_wen(wen0),
    .cfg_addr(addr0), .cfg_wdata(wdata0), .cfg_rdata(rdata0),
    .cfg_rdy(rdy0), .locked(locked0), .err_busy(err0)
  );

  mmcm_drp_resp #(.READY_LAT(1), .LOCK_CYCLES(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_ena(ena1), .cfg_wen(wen1),
    .cfg_addr(addr1), .cfg_wdata(wdata1), .cfg_rdata(rdata1),
    .cfg_rdy(rdy1), .locked(locked1), .err_busy(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 128; a++) model[s][a] = drp_default(7'(a));
      last_rd[s] = 32'h0;
    end
  endtask

  // One request, issued in the cycle after the call point; returns in the cfg_rdy cycle
  task automatic do_req(input bit sel, input bit wen, input logic [6:0] addr,
                        input logic [31:0] wdata);
    int          lat;
    logic [31:0] exp;
    @(posedge clk); #1;
    if (!wen) exp_q.push_back({16'h0, model[sel][addr]});
    if (sel) begin ena1 = 1; wen1 = wen; addr1 = addr; wdata1 = wdata; end
    else     begin ena0 = 1; wen0 = wen; addr0 = addr; wdata0 = wdata; end
    @(posedge clk); #1;
    ena0 = 0; ena1 = 0;
    lat = 1;
    while (!(sel ? rdy1 : rdy0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(sel ? "latency_rl1" : "latency_rl4", lat, sel ? 2 : 5);
    if (!wen) begin
      exp = exp_q.pop_front();
      chk("read_data", sel ? rdata1 : rdata0, exp);
      last_rd[sel] = exp;
    end else begin
      chk("rdata_hold_on_write", sel ? rdata1 : rdata0, last_rd[sel]);
      model[sel][addr] = wdata[15:0];
    end
    $display("dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d", sel, wen ? "WR" : "RD",
             addr, wdata, sel ? rdata1 : rdata0, lat);
  endtask

  initial begin
    int n;
    logic [31:0] exp;
    model_reset();

    // Reset values
    #23;
    chk("rst_rdy", rdy0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_err", err0, 0);
    chk("rst_locked", locked0, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
`ifdef DRP_RESP_LOCK_EN
    chk("lock_after_first_edge", locked0, 0);
    n = 0;
    while (!locked0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("lock_rise_after_reset", n, 64);
`else
    chk("lock_after_first_edge", locked0, 1);
`endif

    // Default read, write then immediate read-back
    do_req(0, 0, 7'h14, 32'h0);
    chk("dflt14_literal", rdata0, 32'h0000_1208);
    do_req(0, 1, 7'h08, 32'h0000_A5C3);
    do_req(0, 0, 7'h08, 32'h0);
    chk("rdback_08_literal", rdata0, 32'h0000_A5C3);
    chk("err_after_b2b", err0, 0);
    do_req(0, 0, 7'h00, 32'h0);
    do_req(0, 1, 7'h7F, 32'hDEAD_FFFF);
    do_req(0, 0, 7'h7F, 32'h0);
    do_req(0, 0, 7'h06, 32'h0);

    // Lock behaviour on writes
`ifdef DRP_RESP_LOCK_EN
    do_req(0, 1, 7'h09, 32'h0000_0123);
    chk("lock_low_done1", locked0, 0);
    repeat (29) begin @(posedge clk); #1; end
    do_req(0, 1, 7'h09, 32'h0000_0456);
    chk("lock_low_done2", locked0, 0);
    n = 0;
    while (!locked0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("lock_rise_after_write", n, 64);
`else
    do_req(0, 1, 7'h09, 32'h0000_0123);
    chk("lock_high_on_write", locked0, 1);
`endif
    do_req(0, 0, 7'h09, 32'h0);

    // Request 2 cycles after acceptance is dropped
    @(posedge clk); #1;
    exp_q.push_back({16'h0, model[0][7'h0A]});
    ena0 = 1; wen0 = 0; addr0 = 7'h0A;
    @(posedge clk); #1; ena0 = 0;
    @(posedge clk); #1; ena0 = 1; wen0 = 1; addr0 = 7'h0B; wdata0 = 32'h1234;
    @(posedge clk); #1; ena0 = 0;
    n = 0;
    repeat (12) begin
      if (rdy0) begin
        n++;
        exp = exp_q.pop_front();
        chk("drop_read_data", rdata0, exp);
        last_rd[0] = exp;
      end
      @(posedge clk); #1;
    end
    chk("drop_rdy_count", n, 1);
    chk("drop_err_set", err0, 1);
    $display("dut0 DROP test rdy_count=%0d err_busy=%0d", n, err0);
    do_req(0, 0, 7'h0B, 32'h0);
    chk("dflt0B_literal", rdata0, 32'h0000_0080);
    chk("err_sticky", err0, 1);

    // Reset in the middle of a write
    @(posedge clk); #1;
    ena0 = 1; wen0 = 1; addr0 = 7'h0A; wdata0 = 32'h0000_BEEF;
    @(posedge clk); #1; ena0 = 0;
    @(posedge clk); #1;
    rst_n = 0;
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (rdy0) n++; end
    rst_n = 1;
    repeat (8) begin @(posedge clk); #1; if (rdy0) n++; end
    chk("rst_no_rdy", n, 0);
    chk("rst_err_clear", err0, 0);
    chk("rst_rdata_clear", rdata0, 0);
    $display("dut0 RESET during write rdy_count=%0d", n);
    model_reset();
    do_req(0, 0, 7'h0A, 32'h0);
    chk("dflt0A_literal", rdata0, 32'h0000_1083);
    do_req(0, 0, 7'h08, 32'h0);

    // READY_LAT=1, back-to-back requests
    do_req(1, 1, 7'h10, 32'h0000_0123);
    do_req(1, 0, 7'h10, 32'h0);
    do_req(1, 0, 7'h14, 32'h0);
    do_req(1, 1, 7'h15, 32'hFFFF_CAFE);
    do_req(1, 0, 7'h15, 32'h0);
    do_req(1, 0, 7'h06, 32'h0);
    chk("rl1_no_drops", err1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
